decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- IF/ID pipeline stage directly upstream of the register file.
- Latches the fetched instruction and drives the register file's rs/rt/rd index inputs.
- Produces registered control and immediate fields that arrive in the same cycle as the register file's rsOut/rtOut read data.
- Detects load-use hazards, inserts bubbles, honours downstream stall and branch flush.

Parameters:
- RESET_PC, 32'h00000000, value of pcOut after reset.
- LINK_REG, 31, destination index written by JAL.

Ports:
- clock  input  1  rising-edge clock shared with the register file
- reset  input  1  asynchronous, active-high reset
- instrValid  input  1  fetch presents a valid instruction
- instruction  input  32  fetched instruction word
- pcIn  input  32  PC of the fetched instruction
- exStall  input  1  downstream cannot accept; hold all outputs
- flush  input  1  squash the held and incoming instruction (taken branch/jump)
- fetchStall  output  1  fetch must re-present the same instruction next cycle
- rsIdx  output  5  register file rsIn (combinational from latched instruction)
- rtIdx  output  5  register file rtIn (combinational)
- rdIdx  output  5  write destination, registered
- immOut  output  32  extended immediate, registered
- aluOp  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 LUI
- aluSrcImm, memRead, memWrite, regWrite, branchEq, branchNe, jump, jumpReg  output  1 each  registered controls
- outValid  output  1  registered outputs hold a real instruction
- pcOut  output  32  PC of the instruction in outputs

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-high.
- Reset values:
  - all control outputs, outValid and fetchStall = 0
  - rdIdx = 0, immOut = 0, aluOp = 0, pcOut = RESET_PC
  - IF/ID latch holds NOP (0x00000000) with latchValid = 0
- Pipeline:
  - Instruction accepted at edge N (instrValid=1, fetchStall=0, exStall=0) sits in the IF/ID latch during cycle N..N+1.
  - rsIdx/rtIdx reflect it combinationally, so the register file samples them at edge N+1.
  - Decoded outputs register at edge N+1, aligned with rsOut/rtOut.
  - Latency: one edge from latch to outputs.
- Decode (opcode = top 6 bits; rs, rt, rd, shamt, funct, imm16 at the standard MIPS positions):
  - R-type (opcode 0):
    - ADD/ADDU 0x20/0x21, SUB/SUBU 0x22/0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A: rdIdx = rd, regWrite = 1.
    - SLL 0x00 / SRL 0x02: immOut = zero-extended shamt, aluSrcImm = 1.
    - JR 0x08: jumpReg = 1, regWrite = 0.
  - I-type, rdIdx = rt, aluSrcImm = 1:
    - ADDI/ADDIU 0x08/0x09 and SLTI 0x0A: sign-extend imm16.
    - ANDI 0x0C / ORI 0x0D: zero-extend imm16.
    - LUI 0x0F: immOut = {imm16, 16'h0}.
    - LW 0x23: memRead = 1, regWrite = 1.
    - SW 0x2B: memWrite = 1, regWrite = 0, rdIdx = 0.
  - BEQ 0x04 / BNE 0x05: aluOp SUB, immOut = sign-extended imm16 shifted left 2, regWrite = 0.
  - J 0x02: jump = 1. JAL 0x03: jump = 1, regWrite = 1, rdIdx = LINK_REG, immOut = zero-extended 26-bit target.
  - Any destination of 0 forces regWrite = 0.
  - Unsupported opcode/funct: decoded as NOP (all controls 0), outValid still follows latchValid.
- State machine:
  - RUN: normal flow.
  - BUBBLE: entered when outputs hold an LW with rdIdx != 0 and the latched instruction reads that register as rs, or as rt for R-type/SW/BEQ/BNE.
    - Entry cycle: fetchStall = 1, outputs load a bubble (outValid = 0, controls 0), latch held.
    - Next edge returns to RUN.
  - HOLD: while exStall = 1, outputs and latch frozen, fetchStall = 1; return to RUN on exStall = 0.
  - exStall has priority over hazard detection. flush has priority over everything.
- flush = 1 at an edge: latch becomes NOP (latchValid = 0), outputs become a bubble, state goes to RUN, fetchStall = 0 the following cycle.
- instrValid = 0 with no stall: latch loads NOP (latchValid = 0).

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- With it defined:
  - Extra output port illegalInstr (1, registered, reset 0) pulses for one cycle when an unsupported encoding with latchValid = 1 reaches the outputs.
  - That instruction's outValid is forced to 0.
- Without it: port absent; unsupported encodings pass as NOPs with outValid = 1.

Test Plan:
- Reset: assert reset mid-stream with outValid = 1 -> all outputs zero immediately (asynchronously), pcOut = RESET_PC.
- ADDI: ADDI $5,$3,-4 (0x2065FFFC) -> next edge rsIdx = 3 during latch; rdIdx = 5, immOut = 0xFFFFFFFC, aluOp = 0, regWrite = 1, aluSrcImm = 1.
- Load-use: LW $8,0($2) then ADD $9,$8,$1 -> one bubble (outValid = 0), fetchStall high for one cycle; ADD emerges one edge later with rdIdx = 9.
- Downstream stall: exStall held 3 cycles with ORI in outputs -> outputs, latch and rsIdx unchanged, fetchStall = 1 throughout; resumes without loss or duplication.
- Flush: flush during a BEQ with an SW latched -> SW never reaches outputs (outValid = 0, memWrite = 0).
- JAL / trap: JAL 0x0C000010 -> rdIdx = 31, jump = 1, immOut = 0x00000010. Opcode 0x3F with DECODE_ILLEGAL_TRAP_EN -> illegalInstr = 1 for one cycle, outValid = 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: IF/ID latch plus instruction decode feeding the register file.
//
// The fetched instruction is held in the IF/ID latch; rsIdx/rtIdx are driven
// combinationally from it so the register file samples them on the same edge
// that registers the decoded controls. The registered outputs therefore line
// up with the register file's rsOut/rtOut read data.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   instrValid/instruction  fetched instruction word and its valid flag
//   pcIn                    PC of the fetched instruction
//   exStall                 downstream busy: freeze outputs and latch
//   flush                   squash latched and incoming instruction
//   fetchStall              fetch must re-present its instruction next cycle
//   rsIdx, rtIdx            register file read indices (combinational)
//   rdIdx, immOut, aluOp    registered destination, immediate, ALU operation
//   aluSrcImm .. jumpReg    registered control strobes
//   outValid, pcOut         registered valid flag and PC of the output slot
//   illegalInstr            (DECODE_ILLEGAL_TRAP_EN only) one-cycle pulse when
//                           an unsupported encoding reaches the outputs
//
// Build option: define DECODE_ILLEGAL_TRAP_EN to add illegalInstr and drop
// outValid for unsupported encodings.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [31:0] instruction,
  input  logic [31:0] pcIn,
  input  logic        exStall,
  input  logic        flush,
  output logic        fetchStall,
  output logic [4:0]  rsIdx,
  output logic [4:0]  rtIdx,
  output logic [4:0]  rdIdx,
  output logic [31:0] immOut,
  output logic [3:0]  aluOp,
  output logic        aluSrcImm,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        branchEq,
  output logic        branchNe,
  output logic        jump,
  output logic        jumpReg,
  output logic        outValid,
  output logic [31:0] pcOut
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        illegalInstr
`endif
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLL = 4'd7,
                         OP_SRL = 4'd8, OP_LUI = 4'd9;

  typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src, mr, mw, rw, beq, bne, j, jr;
  } ctl_t;

  state_t      state, state_nxt;
  logic [31:0] instr_q, instr_nxt, pc_q, pc_nxt;
  logic        lv_q, lv_nxt;
  ctl_t        ctl_q, ctl_nxt, dec;
  logic        dec_legal;
  logic        load_use, uses_rt;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ill_q, ill_nxt;
`endif

  logic [5:0]  opc, funct;
  logic [4:0]  rdf, shamt;
  logic [15:0] imm16;
  logic [31:0] sext;

  assign opc   = instr_q[31:26];
  assign rsIdx = instr_q[25:21];
  assign rtIdx = instr_q[20:16];
  assign rdf   = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];
  assign sext  = {{16{imm16[15]}}, imm16};

  // Decode of the latched word; valid/pc are filled in by the output logic.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    case (opc)
      6'h00: begin
        dec.rd = rdf;
        dec.rw = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.op = OP_ADD;
          6'h22, 6'h23: dec.op = OP_SUB;
          6'h24:        dec.op = OP_AND;
          6'h25:        dec.op = OP_OR;
          6'h26:        dec.op = OP_XOR;
          6'h27:        dec.op = OP_NOR;
          6'h2A:        dec.op = OP_SLT;
          6'h00: begin dec.op = OP_SLL; dec.src = 1'b1; dec.imm = {27'd0, shamt}; end
          6'h02: begin dec.op = OP_SRL; dec.src = 1'b1; dec.imm = {27'd0, shamt}; end
          6'h08: begin dec.jr = 1'b1; dec.rd = '0; dec.rw = 1'b0; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.op = OP_ADD; dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = sext; end
      6'h0A: begin dec.op = OP_SLT; dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = sext; end
      6'h0C: begin dec.op = OP_AND; dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = {16'd0, imm16}; end
      6'h0D: begin dec.op = OP_OR;  dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = {16'd0, imm16}; end
      6'h0F: begin dec.op = OP_LUI; dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = {imm16, 16'd0}; end
      6'h23: begin dec.op = OP_ADD; dec.rd = rtIdx; dec.rw = 1'b1; dec.src = 1'b1; dec.imm = sext; dec.mr = 1'b1; end
      6'h2B: begin dec.op = OP_ADD; dec.src = 1'b1; dec.imm = sext; dec.mw = 1'b1; end
      6'h04: begin dec.op = OP_SUB; dec.beq = 1'b1; dec.imm = {sext[29:0], 2'b00}; end
      6'h05: begin dec.op = OP_SUB; dec.bne = 1'b1; dec.imm = {sext[29:0], 2'b00}; end
      6'h02: begin dec.j = 1'b1; dec.imm = {6'd0, instr_q[25:0]}; end
      6'h03: begin dec.j = 1'b1; dec.rd = LINK_REG; dec.rw = 1'b1; dec.imm = {6'd0, instr_q[25:0]}; end
      default: dec_legal = 1'b0;
    endcase
    if (dec.rd == 5'd0) dec.rw = 1'b0;
    if (!dec_legal)     dec    = '0;
  end

  // Load-use: LW in the output slot whose destination the latched word reads.
  assign uses_rt  = (opc == 6'h00) || (opc == 6'h2B) || (opc == 6'h04) || (opc == 6'h05);
  assign load_use = ctl_q.valid && ctl_q.mr && (ctl_q.rd != 5'd0) && lv_q &&
                    ((rsIdx == ctl_q.rd) || (uses_rt && (rtIdx == ctl_q.rd)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      lv_q    <= 1'b0;
      ctl_q   <= ctl_t'{pc: RESET_PC, default: '0};
`ifdef DECODE_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      instr_q <= instr_nxt;
      pc_q    <= pc_nxt;
      lv_q    <= lv_nxt;
      ctl_q   <= ctl_nxt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ill_q   <= ill_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = RUN;
    case (state)
      BUBBLE:  if (!flush && exStall) state_nxt = HOLD;
      default: begin
        if (flush)         state_nxt = RUN;
        else if (exStall)  state_nxt = HOLD;
        else if (load_use) state_nxt = BUBBLE;
      end
    endcase
  end

  // Datapath/output selection keyed by the state being entered at the edge.
  always_comb begin
    instr_nxt  = instr_q;
    pc_nxt     = pc_q;
    lv_nxt     = lv_q;
    ctl_nxt    = ctl_q;
    fetchStall = !reset && (state_nxt != RUN);
`ifdef DECODE_ILLEGAL_TRAP_EN
    ill_nxt    = ill_q;
`endif
    if (flush || state_nxt == BUBBLE) begin
      ctl_nxt    = '0;
      ctl_nxt.pc = ctl_q.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ill_nxt    = 1'b0;
`endif
      if (flush) begin
        instr_nxt = '0;
        lv_nxt    = 1'b0;
      end
    end else if (state_nxt == RUN) begin
      ctl_nxt    = lv_q ? dec : '0;
      ctl_nxt.pc = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ctl_nxt.valid = lv_q && dec_legal;
      ill_nxt       = lv_q && !dec_legal;
`else
      ctl_nxt.valid = lv_q;
`endif
      instr_nxt = instrValid ? instruction : '0;
      lv_nxt    = instrValid;
      if (instrValid) pc_nxt = pcIn;
    end
  end

  assign rdIdx     = ctl_q.rd;
  assign immOut    = ctl_q.imm;
  assign aluOp     = ctl_q.op;
  assign aluSrcImm = ctl_q.src;
  assign memRead   = ctl_q.mr;
  assign memWrite  = ctl_q.mw;
  assign regWrite  = ctl_q.rw;
  assign branchEq  = ctl_q.beq;
  assign branchNe  = ctl_q.bne;
  assign jump      = ctl_q.j;
  assign jumpReg   = ctl_q.jr;
  assign outValid  = ctl_q.valid;
  assign pcOut     = ctl_q.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegalInstr = ill_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instrValid = 1'b0, exStall = 1'b0, flush = 1'b0;
  logic [31:0] instruction = '0, pcIn = '0;
  logic        fetchStall, aluSrcImm, memRead, memWrite, regWrite;
  logic        branchEq, branchNe, jump, jumpReg, outValid;
  logic [4:0]  rsIdx, rtIdx, rdIdx;
  logic [31:0] immOut, pcOut;
  logic [3:0]  aluOp;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegalInstr;
`endif

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clock = ~clock;

  decode_stage #(.RESET_PC(RPC), .LINK_REG(5'd31)) dut (
    .clock(clock), .reset(reset), .instrValid(instrValid), .instruction(instruction),
    .pcIn(pcIn), .exStall(exStall), .flush(flush), .fetchStall(fetchStall),
    .rsIdx(rsIdx), .rtIdx(rtIdx), .rdIdx(rdIdx), .immOut(immOut), .aluOp(aluOp),
    .aluSrcImm(aluSrcImm), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .branchEq(branchEq), .branchNe(branchNe), .jump(jump), .jumpReg(jumpReg),
    .outValid(outValid), .pcOut(pcOut)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegalInstr(illegalInstr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid, ill;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src, mr, mw, rw, beq, bne, j, jr;
  } exp_t;

  function automatic exp_t bubble(input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.pc = pc;
    return e;
  endfunction

  // What the output slot must show for a valid latched word.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic legal;
    logic [31:0] se, ze;
    int op;
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    e = bubble(pc);
    legal = 1'b1;
    op = -1;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20, 6'h21: op = 0;
        6'h22, 6'h23: op = 1;
        6'h24: op = 2;
        6'h25: op = 3;
        6'h26: op = 4;
        6'h27: op = 5;
        6'h2A: op = 6;
        6'h00: begin op = 7; e.src = 1; e.imm = 32'(w[10:6]); end
        6'h02: begin op = 8; e.src = 1; e.imm = 32'(w[10:6]); end
        6'h08: e.jr = 1;
        default: legal = 0;
      endcase
      if (op >= 0) begin e.op = 4'(op); e.rd = w[15:11]; e.rw = 1; end
    end else begin
      case (w[31:26])
        6'h08, 6'h09: begin op = 0; e.imm = se; end
        6'h0A: begin op = 6; e.imm = se; end
        6'h0C: begin op = 2; e.imm = ze; end
        6'h0D: begin op = 3; e.imm = ze; end
        6'h0F: begin op = 9; e.imm = w[15:0] << 16; end
        6'h23: begin op = 0; e.imm = se; e.mr = 1; end
        6'h2B: begin e.imm = se; e.mw = 1; e.src = 1; end
        6'h04: begin e.op = 1; e.beq = 1; e.imm = se * 4; end
        6'h05: begin e.op = 1; e.bne = 1; e.imm = se * 4; end
        6'h02: begin e.j = 1; e.imm = 32'(w[25:0]); end
        6'h03: begin e.j = 1; e.imm = 32'(w[25:0]); e.rd = 5'd31; e.rw = 1; end
        default: legal = 0;
      endcase
      if (op >= 0) begin e.op = 4'(op); e.rd = w[20:16]; e.rw = 1; e.src = 1; end
    end
    if (e.rd == 0) e.rw = 0;
    if (!legal) e = bubble(pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.valid = legal;
    e.ill   = !legal;
`else
    e.valid = 1;
`endif
    return e;
  endfunction

  logic [31:0] m_instr, m_pc;
  logic        m_lv, m_accepted, m_haz;
  exp_t        m_out;

  function automatic logic m_hazard();
    logic reads_rt;
    reads_rt = (m_instr[31:26] == 6'h00) || (m_instr[31:26] == 6'h2B) ||
               (m_instr[31:26] == 6'h04) || (m_instr[31:26] == 6'h05);
    return m_out.valid && m_out.mr && m_out.rd != 0 && m_lv &&
           (m_instr[25:21] == m_out.rd || (reads_rt && m_instr[20:16] == m_out.rd));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_instr = '0; m_pc = RPC; m_lv = 0; m_out = bubble(RPC); m_accepted = 0;
    end else begin
      m_haz = m_hazard();
      m_accepted = 0;
      if (flush) begin
        m_out = bubble(m_out.pc); m_instr = '0; m_lv = 0;
      end else if (exStall) begin
        // frozen
      end else if (m_haz) begin
        m_out = bubble(m_out.pc);
      end else begin
        m_out = m_lv ? ref_decode(m_instr, m_pc) : bubble(m_pc);
        if (instrValid) begin
          m_instr = instruction; m_pc = pcIn; m_lv = 1; m_accepted = 1;
        end else begin
          m_instr = '0; m_lv = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_fetchStall", fetchStall, !reset && !flush && (exStall || m_hazard()));
      chk("m_rsIdx", rsIdx, m_instr[25:21]);
      chk("m_rtIdx", rtIdx, m_instr[20:16]);
      chk("m_outValid", outValid, m_out.valid);
      chk("m_pcOut", pcOut, m_out.pc);
      chk("m_rdIdx", rdIdx, m_out.rd);
      chk("m_immOut", immOut, m_out.imm);
      chk("m_aluOp", aluOp, m_out.op);
      chk("m_ctl", {aluSrcImm, memRead, memWrite, regWrite, branchEq, branchNe, jump, jumpReg},
          {m_out.src, m_out.mr, m_out.mw, m_out.rw, m_out.beq, m_out.bne, m_out.j, m_out.jr});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("m_illegalInstr", illegalInstr, m_out.ill);
`endif
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADDI = 32'h2065FFFC, LW8 = 32'h8C480000, ADD9 = 32'h01014820,
                          ORI  = 32'h34C700F0, LUI = 32'h3C031234, SRL = 32'h000520C2,
                          BEQ  = 32'h10220004, SW  = 32'hACA40008, JAL = 32'h0C000010,
                          BAD  = 32'hFC000000;

  localparam int N = 24;
  logic [31:0] prog [0:N-1] = '{
    LW8, ADD9, LW8, 32'hACA80008, LW8, 32'h10280004, LW8, 32'h34C800F0,
    32'h8C400000, 32'h00014820, 32'h00220020, 32'h08000040, 32'h03E00008, 32'h00851822,
    32'h00851827, 32'h0085182A, 32'h00851826, 32'h000520C0, 32'h14220004, 32'h2865FFFC,
    32'h30C7FFFF, 32'h0085183F, BAD, JAL};

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic drv(input logic v, input logic [31:0] w, input logic [31:0] pc);
    instrValid = v; instruction = w; pcIn = pc;
  endtask

  initial begin
    int unsigned idx;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_outValid", outValid, 0);
    chk("reset_pcOut", pcOut, RPC);
    chk("reset_fetchStall", fetchStall, 0);
    reset = 1'b0;

    // ADDI
    drv(1, ADDI, 32'h100); tick();
    chk("addi_rsIdx", rsIdx, 3);
    drv(0, 0, 0); tick();
    chk("addi_rdIdx", rdIdx, 5);
    chk("addi_imm", immOut, 32'hFFFFFFFC);
    chk("addi_ctl", {aluOp, regWrite, aluSrcImm, outValid}, {4'd0, 3'b111});

    // load-use
    drv(1, LW8, 32'h104); tick();
    drv(1, ADD9, 32'h108); tick();
    chk("lu_stall", fetchStall, 1);
    chk("lu_lw", {memRead, rdIdx}, {1'b1, 5'd8});
    drv(1, ORI, 32'h10C); tick();
    chk("lu_bubble", {outValid, fetchStall}, 0);
    tick();
    chk("lu_add", {outValid, rdIdx}, {1'b1, 5'd9});
    chk("lu_add_pc", pcOut, 32'h108);

    // downstream stall
    drv(1, ADDI, 32'h110); tick();
    chk("st_ori", immOut, 32'hF0);
    exStall = 1; drv(1, LUI, 32'h114);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold", {fetchStall, rdIdx, rsIdx, pcOut}, {1'b1, 5'd7, 5'd3, 32'h10C});
    end
    exStall = 0; tick();
    chk("st_addi", {pcOut, rdIdx}, {32'h110, 5'd5});
    drv(1, SRL, 32'h118); tick();
    chk("st_lui", {pcOut, immOut, aluOp}, {32'h114, 32'h12340000, 4'd9});

    // flush
    drv(1, BEQ, 32'h11C); tick();
    chk("srl", {aluOp, immOut, rdIdx}, {4'd8, 32'd3, 5'd4});
    drv(1, SW, 32'h120); tick();
    chk("beq", {branchEq, aluOp, regWrite, immOut}, {1'b1, 4'd1, 1'b0, 32'h10});
    flush = 1; drv(1, JAL, 32'h124); tick();
    chk("fl_bubble", {outValid, memWrite, fetchStall}, 0);
    flush = 0; drv(1, JAL, 32'h200); tick();
    chk("fl_nosw", {outValid, memWrite}, 0);
    drv(0, 0, 0); tick();
    chk("jal", {rdIdx, jump, regWrite, immOut, pcOut}, {5'd31, 2'b11, 32'h10, 32'h200});

    // unsupported encoding
    drv(1, BAD, 32'h300); tick();
    drv(0, 0, 0); tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("bad_trap", {illegalInstr, outValid}, 2'b10);
    tick();
    chk("bad_trap_end", illegalInstr, 0);
`else
    chk("bad_nop", {outValid, regWrite, aluSrcImm, rdIdx, immOut}, {3'b100, 5'd0, 32'd0});
`endif

    // mixed stream checked by the model every cycle
    idx = 0;
    for (int c = 0; c < 400; c++) begin
      drv($urandom_range(0, 5) != 0, prog[idx % N], 32'h1000 + idx * 4);
      exStall = ($urandom_range(0, 6) == 0);
      flush   = ($urandom_range(0, 12) == 0);
      tick();
      if (m_accepted) idx++;
    end
    exStall = 0; flush = 0;

    // asynchronous reset mid-cycle
    drv(1, ADDI, 32'h400); tick();
    drv(0, 0, 0); tick();
    chk("ar_pre", outValid, 1);
    #1 reset = 1;
    #1;
    chk("ar_outs", {outValid, rdIdx, immOut, aluOp, regWrite, aluSrcImm}, 0);
    chk("ar_pc", pcOut, RPC);
    tick();
    reset = 0;
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
